// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: sequences header, payload and
// parity loads, FIFO-full stalls and per-port soft-reset aborts.
module router_fsm #(
  parameter logic [1:0] ADDR_INVALID = 2'b11,
  parameter int         STATE_W      = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       empty2,
  input  logic       soft_reset0,
  input  logic       soft_reset1,
  input  logic       soft_reset2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       write_enb_reg,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q;
  logic [3:0] empty_v, srst_v;

  logic detect_q, wen_q, lfd_q, ld_q;
  logic laf_q, full_q, rst_int_q, busy_q;

  // Code 3 is padded so a reserved address never indexes out of range.
  assign empty_v = {1'b0, empty2, empty1, empty0};
  assign srst_v  = {1'b0, soft_reset2, soft_reset1, soft_reset0};

  always_comb begin
    state_d = state_q;
    if (state_q != DECODE_ADDRESS && srst_v[addr_q]) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && datain != ADDR_INVALID)
            state_d = empty_v[datain] ? LOAD_FIRST_DATA
                                      : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_d = fifo_full ? FIFO_FULL_STATE
                              : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_v[addr_q]) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state, so they track state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DECODE_ADDRESS;
      addr_q    <= 2'b00;
      detect_q  <= 1'b1;
      wen_q     <= 1'b0;
      lfd_q     <= 1'b0;
      ld_q      <= 1'b0;
      laf_q     <= 1'b0;
      full_q    <= 1'b0;
      rst_int_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE_ADDRESS && pkt_valid)
        addr_q <= datain;
      detect_q  <= (state_d == DECODE_ADDRESS);
      lfd_q     <= (state_d == LOAD_FIRST_DATA);
      ld_q      <= (state_d == LOAD_DATA);
      full_q    <= (state_d == FIFO_FULL_STATE);
      laf_q     <= (state_d == LOAD_AFTER_FULL);
      rst_int_q <= (state_d == CHECK_PARITY_ERROR);
      wen_q     <= (state_d == LOAD_DATA) ||
                   (state_d == LOAD_PARITY) ||
                   (state_d == LOAD_AFTER_FULL);
      busy_q    <= (state_d != DECODE_ADDRESS) &&
                   (state_d != LOAD_DATA);
    end
  end

  assign detect_addr   = detect_q;
  assign write_enb_reg = wen_q;
  assign lfd_state     = lfd_q;
  assign ld_state      = ld_q;
  assign laf_state     = laf_q;
  assign full_state    = full_q;
  assign rst_int_reg   = rst_int_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: a phase-level packet model predicts
// the strobes after every clock and a monitor compares them.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid, fifo_full;
  logic [1:0] datain;
  logic       empty0, empty1, empty2;
  logic       soft_reset0, soft_reset1, soft_reset2;
  logic       parity_done, low_pkt_valid;
  logic       detect_addr, write_enb_reg, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
    .datain(datain), .fifo_full(fifo_full),
    .empty0(empty0), .empty1(empty1), .empty2(empty2),
    .soft_reset0(soft_reset0), .soft_reset1(soft_reset1),
    .soft_reset2(soft_reset2), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_addr(detect_addr), .write_enb_reg(write_enb_reg),
    .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       pv;
    bit [1:0] da;
    bit       ff;
    bit [3:0] em;
    bit [3:0] sr;
    bit       pd;
    bit       lpv;
  } stim_t;

  // Packet phases as the source sees them.
  typedef enum int {
    PH_IDLE, PH_WAIT, PH_HEADER, PH_PAYLOAD,
    PH_STALLED, PH_REPLAY, PH_PARITY, PH_CHECK
  } phase_t;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  stim_t  cur;
  phase_t ph;
  int     port;
  string  tag;
  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;

  // {detect, wen, lfd, ld, laf, full, rst_int, busy}
  function automatic logic [7:0] expv(phase_t p);
    case (p)
      PH_IDLE:    return 8'b1000_0000;
      PH_WAIT:    return 8'b0000_0001;
      PH_HEADER:  return 8'b0010_0001;
      PH_PAYLOAD: return 8'b0101_0000;
      PH_STALLED: return 8'b0000_0101;
      PH_REPLAY:  return 8'b0100_1001;
      PH_PARITY:  return 8'b0100_0001;
      default:    return 8'b0000_0011;
    endcase
  endfunction

  function automatic void model_step(stim_t s);
    if (ph != PH_IDLE && s.sr[port]) begin
      ph = PH_IDLE;
      return;
    end
    case (ph)
      PH_IDLE: if (s.pv) begin
        port = int'(s.da);
        if (s.da != 2'b11)
          ph = s.em[s.da] ? PH_HEADER : PH_WAIT;
      end
      PH_WAIT:    if (s.em[port]) ph = PH_HEADER;
      PH_HEADER:  ph = PH_PAYLOAD;
      PH_PAYLOAD: ph = s.ff ? PH_STALLED
                     : (s.pv ? PH_PAYLOAD : PH_PARITY);
      PH_STALLED: if (!s.ff) ph = PH_REPLAY;
      PH_REPLAY:  ph = s.pd ? PH_IDLE
                     : (s.lpv ? PH_PARITY : PH_PAYLOAD);
      PH_PARITY:  ph = PH_CHECK;
      default:    ph = s.ff ? PH_STALLED : PH_IDLE;
    endcase
  endfunction

  task automatic drive();
    pkt_valid     = cur.pv;
    datain        = cur.da;
    fifo_full     = cur.ff;
    empty0        = cur.em[0];
    empty1        = cur.em[1];
    empty2        = cur.em[2];
    soft_reset0   = cur.sr[0];
    soft_reset1   = cur.sr[1];
    soft_reset2   = cur.sr[2];
    parity_done   = cur.pd;
    low_pkt_valid = cur.lpv;
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive();
      model_step(cur);
      exp_q.push_back('{expv(ph), tag});
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    ph   = PH_IDLE;
    port = 0;
    exp_q.push_back('{expv(ph), "async_reset"});
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic idle_defaults();
    cur.pv = 0; cur.da = 0; cur.ff = 0;
    cur.em = 4'b0111; cur.sr = 0;
    cur.pd = 0; cur.lpv = 0;
  endtask

  function automatic logic [7:0] got();
    return {detect_addr, write_enb_reg, lfd_state, ld_state,
            laf_state, full_state, rst_int_reg, busy};
  endfunction

  function automatic void compare(exp_t e);
    checks++;
    if (got() !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               e.tag, got(), e.v, $time);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    if (resetn && exp_q.size() > 0) compare(exp_q.pop_front());
  end

  always @(negedge resetn) begin
    #1;
    if (exp_q.size() > 0) compare(exp_q.pop_front());
  end

  initial begin
    idle_defaults();
    drive();
    ph = PH_IDLE;
    port = 0;
    async_reset();

    tag = "normal_pkt";
    cur.pv = 1; cur.da = 2'b01;
    step(1);
    cur.da = 2'b10;
    step(4);
    cur.pv = 0;
    step(3);

    tag = "busy_fifo";
    cur.pv = 1; cur.da = 2'b10; cur.em = 4'b0011;
    step(5);
    cur.em = 4'b0111;
    step(2);

    tag = "full_stall";
    cur.ff = 1;
    step(3);
    cur.ff = 0;
    step(2);
    cur.pv = 0;
    step(3);

    tag = "invalid_addr";
    cur.pv = 1; cur.da = 2'b11;
    step(3);

    tag = "soft_reset";
    cur.da = 2'b00; cur.em = 4'b0110;
    step(2);
    cur.sr = 4'b0010;
    step(1);
    cur.sr = 4'b0001; cur.pv = 0;
    step(2);
    cur.sr = 0; cur.em = 4'b0111;

    tag = "simultaneous";
    cur.pv = 1; cur.da = 2'b01;
    step(2);
    cur.pv = 0; cur.ff = 1;
    step(1);
    cur.ff = 0; cur.lpv = 1;
    step(3);
    cur.lpv = 0;
    step(1);

    tag = "parity_done";
    cur.pv = 1; cur.da = 2'b00;
    step(2);
    cur.ff = 1;
    step(1);
    cur.ff = 0; cur.pd = 1;
    step(3);
    cur.pd = 0; cur.pv = 0;

    tag = "reset_mid_pkt";
    cur.pv = 1; cur.da = 2'b10;
    step(3);
    async_reset();
    step(2);

    tag = "random";
    for (int i = 0; i < 800; i++) begin
      cur.pv  = $urandom_range(0, 3) != 0;
      cur.da  = 2'($urandom_range(0, 3));
      cur.ff  = $urandom_range(0, 4) == 0;
      cur.em  = {1'b0, 3'($urandom_range(0, 7) | $urandom_range(0, 7))};
      cur.sr  = {1'b0, 3'($urandom_range(0, 31) == 0 ?
                           $urandom_range(1, 7) : 0)};
      cur.pd  = $urandom_range(0, 3) == 0;
      cur.lpv = $urandom_range(0, 3) == 0;
      step(1);
      if (i % 197 == 100) async_reset();
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control FSM for the 1x3 packet router; sequences the input register block and the synchroniser for each packet.
- Decodes the 2-bit destination in the header byte and waits for the target FIFO to drain if needed.
- Steps through header, payload and parity loads; stalls on FIFO full; aborts on a per-port soft reset.
- Drives detect_addr / write-enable / load-phase strobes; `busy` back-pressures the packet source.

Parameters:
ADDR_INVALID, 2'b11, reserved destination code; a header carrying it is ignored.
STATE_W, 3, state register width (8 states, binary encoded).

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source has a valid byte this cycle; falling edge marks end of payload
datain  input  2  destination address field (header bits [1:0])
fifo_full  input  1  FIFO currently selected by synchroniser is full
empty0  input  1  FIFO0 empty
empty1  input  1  FIFO1 empty
empty2  input  1  FIFO2 empty
soft_reset0  input  1  FIFO0 timed out
soft_reset1  input  1  FIFO1 timed out
soft_reset2  input  1  FIFO2 timed out
parity_done  input  1  register block has loaded parity byte
low_pkt_valid  input  1  register block saw pkt_valid drop while full
detect_addr  output  1  synchroniser latches destination
write_enb_reg  output  1  synchroniser may assert FIFO write enable
lfd_state  output  1  loading header byte
ld_state  output  1  loading payload byte
laf_state  output  1  load-after-full (replay held byte)
full_state  output  1  stalled on full FIFO
rst_int_reg  output  1  clear internal parity registers / check parity
busy  output  1  source must hold current byte

Behaviour:
- State register: async clear to DECODE_ADDRESS when resetn=0; otherwise updates on rising clk.
- Reset output values: detect_addr=1; all other outputs 0.
- Outputs are Moore, decoded from the current state only. No output depends on an input in the same cycle.
- addr_q (2 bits):
  - Captured from datain on the clk edge where state=DECODE_ADDRESS and pkt_valid=1.
  - Reset value 0.
  - Selects the empty/soft_reset bit checked in later states.
- Next-state priority: resetn, then soft_reset[addr_q] (only when state!=DECODE_ADDRESS; forces DECODE_ADDRESS from any state), then the table below.
- DECODE_ADDRESS:
  - pkt_valid=1, datain!=ADDR_INVALID and empty[datain]=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, datain!=ADDR_INVALID and empty[datain]=0 -> WAIT_TILL_EMPTY.
  - Otherwise, including datain=ADDR_INVALID -> stay.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
  - fifo_full has priority when it rises in the same cycle pkt_valid drops.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
- Output decode:
  - detect_addr = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - full_state = FIFO_FULL_STATE.
  - laf_state = LOAD_AFTER_FULL.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Unused state encodings -> DECODE_ADDRESS on the next clock.
- Latency: header accepted to first payload write enable = 2 clocks (DECODE->LFD->LD).
- resetn deassertion mid-packet: FSM restarts in DECODE_ADDRESS; the partial packet is discarded by the soft-reset / FIFO logic, not by this block.

Test Plan:
- Reset: resetn=0 asynchronously mid-cycle -> state=DECODE_ADDRESS immediately; detect_addr=1, busy=0, write_enb_reg=0.
- Normal packet:
  - Stimulus: pkt_valid=1, datain=2'b01, empty1=1; 4 payload cycles; then pkt_valid=0.
  - Required: state sequence DECODE->LFD->LD x4->LOAD_PARITY->CHECK_PARITY_ERROR->DECODE.
  - Required: lfd_state=1 for exactly 1 cycle; rst_int_reg=1 for 1 cycle.
- Busy FIFO:
  - Stimulus: datain=2'b10, empty2=0 held for 5 cycles, then empty2=1.
  - Required: WAIT_TILL_EMPTY for 5 cycles with busy=1, then LOAD_FIRST_DATA.
- Full stall:
  - Stimulus: in LOAD_DATA assert fifo_full=1 for 3 cycles, with low_pkt_valid=0 and parity_done=0.
  - Required: full_state=1 for 3 cycles, busy=1; then laf_state=1 for 1 cycle; then back to LOAD_DATA.
- Invalid address and soft reset:
  - datain=2'b11 with pkt_valid=1 -> FSM stays in DECODE_ADDRESS.
  - Packet to port 0 in WAIT_TILL_EMPTY, soft_reset0=1 -> DECODE_ADDRESS next clock.
  - soft_reset1=1 in the same situation -> no effect.
- Simultaneous events:
  - In LOAD_DATA, fifo_full=1 and pkt_valid=0 in the same cycle -> FIFO_FULL_STATE.
  - Then fifo_full=0 with low_pkt_valid=1 -> LOAD_AFTER_FULL->LOAD_PARITY.
